// File: rtl/mandelbrot_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : mandelbrot_scan_engine
// Brief    : Raster walker with a one-iteration-per-clock fixed-point Mandelbrot /
//            Julia core, streaming per-pixel results over valid/ready.
//            Optional macro MANDEL_ABORT_EN adds an abort input.
// Revision : 1.0 - initial release
// ============================================================================
module mandelbrot_scan_engine #(
    parameter int BITWIDTH  = 10,
    parameter int FRAC_BITS = 7,
    parameter int CTRWIDTH  = 10,
    parameter int OUT_WIDTH = 4,
    parameter int MAX_W     = 320,
    parameter int MAX_H     = 240
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    output logic                          busy,
    input  logic [$clog2(MAX_W+1)-1:0]    img_w,
    input  logic [$clog2(MAX_H+1)-1:0]    img_h,
    input  logic [CTRWIDTH-1:0]           max_ctr,
    input  logic [$clog2(CTRWIDTH)-1:0]   ctr_shift,
    input  logic [BITWIDTH-1:0]           step_x,
    input  logic [BITWIDTH-1:0]           step_y,
    input  logic [BITWIDTH-1:0]           cr_offset,
    input  logic [BITWIDTH-1:0]           ci_offset,
    input  logic                          julia_mode,
    input  logic [BITWIDTH-1:0]           julia_cr,
    input  logic [BITWIDTH-1:0]           julia_ci,
    output logic                          pix_valid,
    input  logic                          pix_ready,
    output logic [OUT_WIDTH-1:0]          pix_ctr,
    output logic [$clog2(MAX_W)-1:0]      pix_x,
    output logic [$clog2(MAX_H)-1:0]      pix_y,
    output logic                          pix_last,
`ifdef MANDEL_ABORT_EN
    input  logic                          abort,
`endif
    output logic                          frame_done
);

    localparam int c_WW = $clog2(MAX_W + 1);
    localparam int c_HW = $clog2(MAX_H + 1);
    localparam int c_XW = $clog2(MAX_W);
    localparam int c_YW = $clog2(MAX_H);
    localparam int c_SW = $clog2(CTRWIDTH);
    localparam int c_EW = BITWIDTH + 3;
    localparam int c_PW = 2 * BITWIDTH;
    localparam logic [c_PW:0] c_ESC_LIM = (c_PW + 1)'(4 << FRAC_BITS);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_ITER = 2'd2;
    localparam logic [1:0] c_OUT  = 2'd3;

    logic w_abort;
`ifdef MANDEL_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    logic [1:0]           r_state, w_next_state;
    logic [c_WW-1:0]      r_w;
    logic [c_HW-1:0]      r_h;
    logic [CTRWIDTH-1:0]  r_max_ctr, r_ctr;
    logic [c_SW-1:0]      r_ctr_shift;
    logic [BITWIDTH-1:0]  r_step_x, r_step_y, r_cr_offset, r_julia_cr, r_julia_ci;
    logic                 r_julia_mode, r_ovf, r_frame_done;
    logic [c_XW-1:0]      r_x;
    logic [c_YW-1:0]      r_y;
    logic [BITWIDTH-1:0]  r_pc, r_pi, r_cr, r_ci, r_zr, r_zi;

    // Full-width signed products of the current z
    logic signed [c_PW-1:0] w_zr_w, w_zi_w, w_sq_r, w_sq_i, w_xy;
    logic [c_EW-1:0]        w_zr_next, w_zi_next;
    logic [c_PW:0]          w_mag;
    logic                   w_esc, w_ovf_next, w_iter_done;
    logic                   w_x_end, w_y_end, w_last, w_frame_done;

    assign w_zr_w = {{BITWIDTH{r_zr[BITWIDTH-1]}}, r_zr};
    assign w_zi_w = {{BITWIDTH{r_zi[BITWIDTH-1]}}, r_zi};
    assign w_sq_r = (w_zr_w * w_zr_w) >>> FRAC_BITS;
    assign w_sq_i = (w_zi_w * w_zi_w) >>> FRAC_BITS;
    assign w_xy   = (w_zr_w * w_zi_w) >>> (FRAC_BITS - 1);

    assign w_zr_next = w_sq_r[c_EW-1:0] - w_sq_i[c_EW-1:0] + {{3{r_cr[BITWIDTH-1]}}, r_cr};
    assign w_zi_next = w_xy[c_EW-1:0] + {{3{r_ci[BITWIDTH-1]}}, r_ci};

    // A result fits BITWIDTH signed only if its top bits are pure sign extension
    assign w_ovf_next =
        (w_zr_next[c_EW-1:BITWIDTH-1] != {(c_EW-BITWIDTH+1){w_zr_next[BITWIDTH-1]}}) ||
        (w_zi_next[c_EW-1:BITWIDTH-1] != {(c_EW-BITWIDTH+1){w_zi_next[BITWIDTH-1]}});

    // Squares are non-negative, so an unsigned sum one bit wider cannot overflow
    assign w_mag       = {1'b0, w_sq_r} + {1'b0, w_sq_i};
    assign w_esc       = (w_mag >= c_ESC_LIM);
    assign w_iter_done = w_esc || r_ovf || (r_ctr == r_max_ctr);

    assign w_x_end = (c_WW'(r_x) == r_w - c_WW'(1));
    assign w_y_end = (c_HW'(r_y) == r_h - c_HW'(1));
    assign w_last  = w_x_end && w_y_end;

    assign w_frame_done = ((r_state == c_OUT) && pix_ready && w_last) ||
                          ((r_state != c_IDLE) && w_abort);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_LOAD;
            c_LOAD:  w_next_state = c_ITER;
            c_ITER:  if (w_iter_done) w_next_state = c_OUT;
            c_OUT:   if (pix_ready) w_next_state = w_last ? c_IDLE : c_LOAD;
            default: w_next_state = c_IDLE;
        endcase
        if (w_abort && (r_state != c_IDLE)) w_next_state = c_IDLE;
    end

    always_comb begin
        busy      = (r_state != c_IDLE);
        pix_valid = (r_state == c_OUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_w <= '0;  r_h <= '0;  r_max_ctr <= '0;  r_ctr_shift <= '0;
            r_step_x <= '0;  r_step_y <= '0;  r_cr_offset <= '0;
            r_julia_mode <= 1'b0;  r_julia_cr <= '0;  r_julia_ci <= '0;
            r_x <= '0;  r_y <= '0;  r_pc <= '0;  r_pi <= '0;
            r_cr <= '0;  r_ci <= '0;  r_zr <= '0;  r_zi <= '0;
            r_ctr <= '0;  r_ovf <= 1'b0;  r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_done;
            case (r_state)
                c_IDLE: if (start) begin
                    r_w <= img_w;  r_h <= img_h;
                    r_max_ctr <= max_ctr;  r_ctr_shift <= ctr_shift;
                    r_step_x <= step_x;  r_step_y <= step_y;  r_cr_offset <= cr_offset;
                    r_julia_mode <= julia_mode;  r_julia_cr <= julia_cr;  r_julia_ci <= julia_ci;
                    r_x <= '0;  r_y <= '0;
                    r_pc <= cr_offset;  r_pi <= ci_offset;
                end
                c_LOAD: begin
                    if (r_julia_mode) begin
                        r_cr <= r_julia_cr;  r_ci <= r_julia_ci;
                        r_zr <= r_pc;        r_zi <= r_pi;
                    end else begin
                        r_cr <= r_pc;  r_ci <= r_pi;
                        r_zr <= '0;    r_zi <= '0;
                    end
                    r_ctr <= '0;
                    r_ovf <= 1'b0;
                end
                c_ITER: if (!w_iter_done) begin
                    r_zr  <= w_zr_next[BITWIDTH-1:0];
                    r_zi  <= w_zi_next[BITWIDTH-1:0];
                    r_ctr <= r_ctr + CTRWIDTH'(1);
                    r_ovf <= w_ovf_next;
                end
                c_OUT: if (pix_ready && !w_abort && !w_last) begin
                    if (w_x_end) begin
                        r_x  <= '0;
                        r_y  <= r_y + c_YW'(1);
                        r_pc <= r_cr_offset;
                        r_pi <= r_pi + r_step_y;
                    end else begin
                        r_x  <= r_x + c_XW'(1);
                        r_pc <= r_pc + r_step_x;
                    end
                end
                default: ;
            endcase
        end
    end

    // Counter bits above CTRWIDTH-1 come from the zero padding
    assign pix_ctr    = OUT_WIDTH'({{OUT_WIDTH{1'b0}}, r_ctr} >> r_ctr_shift);
    assign pix_x      = r_x;
    assign pix_y      = r_y;
    assign pix_last   = pix_valid && w_last;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_mandelbrot_scan_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_mandelbrot_scan_engine
// Brief    : Directed scoreboard bench for mandelbrot_scan_engine.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mandelbrot_scan_engine;

    localparam int BW = 10;
    localparam int CW = 10;
    localparam int OW = 4;
    localparam int MW = 320;
    localparam int MH = 240;
    localparam int WW = $clog2(MW + 1);
    localparam int HW = $clog2(MH + 1);
    localparam int XW = $clog2(MW);
    localparam int YW = $clog2(MH);
    localparam int SW = $clog2(CW);

    logic          clk = 1'b0, reset = 1'b1, start = 1'b0, busy;
    logic [WW-1:0] img_w = '0;
    logic [HW-1:0] img_h = '0;
    logic [CW-1:0] max_ctr = '0;
    logic [SW-1:0] ctr_shift = '0;
    logic [BW-1:0] step_x = '0, step_y = '0, cr_offset = '0, ci_offset = '0;
    logic          julia_mode = 1'b0;
    logic [BW-1:0] julia_cr = '0, julia_ci = '0;
    logic          pix_valid, pix_ready = 1'b1, pix_last, frame_done;
    logic [OW-1:0] pix_ctr;
    logic [XW-1:0] pix_x;
    logic [YW-1:0] pix_y;
`ifdef MANDEL_ABORT_EN
    logic          abort = 1'b0;
`endif

    mandelbrot_scan_engine dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy),
        .img_w(img_w), .img_h(img_h), .max_ctr(max_ctr), .ctr_shift(ctr_shift),
        .step_x(step_x), .step_y(step_y), .cr_offset(cr_offset), .ci_offset(ci_offset),
        .julia_mode(julia_mode), .julia_cr(julia_cr), .julia_ci(julia_ci),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_ctr(pix_ctr),
        .pix_x(pix_x), .pix_y(pix_y), .pix_last(pix_last),
`ifdef MANDEL_ABORT_EN
        .abort(abort),
`endif
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] c;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   hs_cyc[$];
    int   n_checks = 0, n_fails = 0;
    int   fd_cnt = 0, fd_exp = 0, ncyc = 0, hs_cnt = 0;
    logic exp_fd = 1'b0;

    // Monitor: pops one expectation per handshake and checks frame_done timing
    always @(negedge clk) begin : mon
        exp_t e;
        logic hs;
        ncyc++;
        if (exp_fd) begin
            n_checks++;
            if (frame_done !== 1'b1) begin
                n_fails++;
                $display("FAIL frame_done_timing: got %0b want 1", frame_done);
            end
            exp_fd = 1'b0;
        end
        if (frame_done === 1'b1) fd_cnt++;
        hs = pix_valid && pix_ready && !reset;
`ifdef MANDEL_ABORT_EN
        hs = hs && !abort;
`endif
        if (hs) begin
            hs_cyc.push_back(ncyc);
            hs_cnt++;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fails++;
                $display("FAIL pix_unexpected: got ctr=%0d x=%0d y=%0d last=%0b want no pixel",
                         pix_ctr, pix_x, pix_y, pix_last);
            end else begin
                e = exp_q.pop_front();
                if (pix_ctr !== e.c || pix_x !== e.x || pix_y !== e.y || pix_last !== e.last) begin
                    n_fails++;
                    $display("FAIL pix: got ctr=%0d x=%0d y=%0d last=%0b want ctr=%0d x=%0d y=%0d last=%0b",
                             pix_ctr, pix_x, pix_y, pix_last, e.c, e.x, e.y, e.last);
                end
            end
            if (pix_last) exp_fd = 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input int c, input int x, input int y, input bit last);
        exp_t e;
        e.c = OW'(c); e.x = XW'(x); e.y = YW'(y); e.last = last;
        exp_q.push_back(e);
    endtask

    task automatic push_uniform(input int w, input int h, input int c);
        for (int yy = 0; yy < h; yy++)
            for (int xx = 0; xx < w; xx++)
                push(c, xx, yy, (xx == w - 1) && (yy == h - 1));
    endtask

    task automatic set_cfg(input int w, input int h, input int mc, input int sh,
                           input int sx, input int sy, input int cro, input int cio,
                           input bit jm, input int jcr, input int jci);
        img_w = WW'(w); img_h = HW'(h); max_ctr = CW'(mc); ctr_shift = SW'(sh);
        step_x = BW'(sx); step_y = BW'(sy); cr_offset = BW'(cro); ci_offset = BW'(cio);
        julia_mode = jm; julia_cr = BW'(jcr); julia_ci = BW'(jci);
    endtask

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_frame(input string name);
        int n = 0;
        fd_exp++;
        while (fd_cnt < fd_exp && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_frame_done"}, fd_cnt, fd_exp);
        chk({name, "_queue_left"}, exp_q.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_valid", pix_valid, 0);
        chk("rst_last", pix_last, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_pix_ctr", pix_ctr, 0);
        chk("rst_pix_x", pix_x, 0);
        chk("rst_pix_y", pix_y, 0);
        @(negedge clk) reset = 1'b0;

        // 2x2 zero plane: every pixel saturates at max_ctr; config changed after start
        set_cfg(2, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0);
        push_uniform(2, 2, 5);
        do_start();
        max_ctr = 1; img_w = 3; cr_offset = 10'd256;
        wait_frame("t1");

        // c = 2.0 escapes after one iteration; latency start -> valid
        set_cfg(1, 1, 100, 0, 0, 0, 256, 0, 0, 0, 0);
        push(1, 0, 0, 1);
        @(negedge clk) start = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end while (!pix_valid && n < 20);
        chk("t2_latency", n, 4);
        wait_frame("t2");

        // max_ctr = 0 over 3x2: one result every 3 cycles
        hs_cyc.delete();
        set_cfg(3, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_uniform(3, 2, 0);
        do_start();
        wait_frame("t3");
        chk("t3_count", hs_cyc.size(), 6);
        for (int i = 1; i < 6 && i < hs_cyc.size(); i++)
            chk("t3_gap", hs_cyc[i] - hs_cyc[i-1], 3);

        // Horizontal stepping: c=-1.0 cycles forever, c=+1.0 escapes at ctr 2
        set_cfg(2, 1, 9, 0, 256, 0, 10'h380, 0, 0, 0, 0);
        push(9, 0, 0, 0);
        push(2, 1, 0, 1);
        do_start();
        wait_frame("steps");

        // Julia z=(255,0), c=(511,0): first update overflows, ends at ctr 1
        set_cfg(1, 1, 15, 0, 0, 0, 255, 0, 1, 511, 0);
        push(1, 0, 0, 1);
        do_start();
        wait_frame("ovf");

        // Backpressure: ten stalled cycles in OUT with outputs frozen
        pix_ready = 1'b0;
        set_cfg(2, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
        push_uniform(2, 1, 3);
        do_start();
        n = 0;
        while (!pix_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t4_valid_seen", pix_valid, 1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t4_stall_hold", {pix_valid, busy, pix_ctr, pix_x, pix_y},
                {1'b1, 1'b1, 4'd3, 9'd0, 8'd0});
        end
        @(posedge clk);
        #1 pix_ready = 1'b1;
        wait_frame("t4");

        // Julia c=0 from z=0.5 never escapes: ctr=20, shift 2 -> 5
        set_cfg(1, 1, 20, 2, 0, 0, 64, 0, 1, 0, 0);
        push(5, 0, 0, 1);
        do_start();
        wait_frame("t5");

        // Asynchronous reset in ITER clears outputs without a clock edge
        set_cfg(1, 1, 50, 0, 0, 0, 0, 0, 0, 0, 0);
        do_start();
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_valid", pix_valid, 0);
        @(negedge clk) reset = 1'b0;
        repeat (60) @(negedge clk);
        chk("async_rst_no_frame_done", fd_cnt, fd_exp);

        set_cfg(1, 1, 100, 0, 0, 0, 256, 0, 0, 0, 0);
        push(1, 0, 0, 1);
        do_start();
        wait_frame("post_rst");

`ifdef MANDEL_ABORT_EN
        // Abort a 4x4 frame around pixel 5, then restart from (0,0)
        n = hs_cnt;
        set_cfg(4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) push(0, i % 4, i / 4, 0);
        do_start();
        while (hs_cnt < n + 5 && (ncyc < 100000)) @(negedge clk);
        @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_valid", pix_valid, 0);
        chk("abort_frame_done", frame_done, 1);
        fd_exp++;
        repeat (30) @(negedge clk);
        chk("abort_fd_count", fd_cnt, fd_exp);
        chk("abort_queue", exp_q.size(), 0);
        set_cfg(2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push_uniform(2, 1, 0);
        do_start();
        wait_frame("abort_restart");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
